rx_display_scheduler: RTL and testbench
=======================================

Name: rx_display_scheduler

Overview:
- Sequences received 7-bit UART characters onto the two-digit hex display path.
- Buffers bursts of incoming bytes in a small FIFO and presents each one for a fixed dwell time, followed by a blank gap.
- Sits between the UART receiver and the seven-segment decoder. It drives the decoder's 7-bit data input and a display-enable that gates the segment outputs, so a burst stays readable instead of being overwritten every byte.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2.
- DWELL_CYCLES, 50000000, clock cycles each byte is displayed; minimum 1.
- GAP_CYCLES, 5000000, clock cycles of blanking between consecutive bytes; minimum 1.
- CNT_W, 26, width of the dwell/gap counter; must hold max(DWELL_CYCLES, GAP_CYCLES).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  single-cycle strobe: rx_data is a new character.
- rx_data  input  7  received character.
- hold  input  1  while high, freezes the dwell/gap counter (display pauses on the current byte).
- clear_overflow  input  1  clears the sticky overflow flag.
- data_out  output  7  byte to the decoder; registered.
- display_en  output  1  high while a byte is being shown; the decoder outputs are blanked when low.
- fifo_count  output  $clog2(DEPTH)+1  number of buffered bytes not yet shown.
- busy  output  1  high when state is not IDLE or fifo_count is nonzero.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (async, active-high, any time including mid-dwell):
  - data_out=0, display_en=0, fifo_count=0, busy=0, overflow=0.
  - FIFO pointers cleared; state=IDLE; counter=0.
- FIFO write:
  - On a clock edge with rx_valid=1, the byte is written if fifo_count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1.
- Overflow flag:
  - clear_overflow=1 clears it.
  - If a drop and clear_overflow coincide, overflow ends at 1 (set wins).
- FIFO pop: occurs only on the transitions into SHOW. The popped byte is loaded into data_out at that edge.
- States:
  - IDLE: display_en=0; data_out holds the last value. If fifo_count>0, pop, load counter=DWELL_CYCLES-1, go to SHOW.
  - SHOW: display_en=1.
    - If hold=1, the counter is frozen.
    - Otherwise, if counter=0, load counter=GAP_CYCLES-1 and go to GAP.
    - Otherwise decrement the counter.
  - GAP: display_en=0.
    - If hold=1, the counter is frozen.
    - Otherwise, if counter=0: when fifo_count>0, pop, load DWELL_CYCLES-1 and go to SHOW; else go to IDLE.
    - Otherwise decrement the counter.
- Latency: rx_valid high in cycle N, with the FIFO empty and state IDLE, gives data_out=byte and display_en=1 from cycle N+2.
- Display time per byte:
  - Exactly DWELL_CYCLES cycles of display_en=1, then exactly GAP_CYCLES cycles of display_en=0 (hold low).
  - Back-to-back bytes therefore repeat every DWELL_CYCLES+GAP_CYCLES.
- FIFO pointers wrap modulo DEPTH. fifo_count is exact; it is never DEPTH+1.
- hold asserted in IDLE has no effect; a pending pop still proceeds.
- busy is combinational from state and fifo_count.

Decomposition:
- Shared package rx_disp_pkg:
  - state enum {IDLE, SHOW, GAP}.
  - default constants for DWELL_CYCLES and GAP_CYCLES.
  - the count-width function.
- Sub-module rx_disp_fifo:
  - parameterised DEPTH × 7-bit synchronous FIFO.
  - ports: push, pop, din, dout, count, full, empty.
  - async active-high reset.
- The scheduler FSM and counter live in the top module.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2, DEPTH=4):
1. Single byte: rx_valid with 7'h35 at cycle 0 → display_en=1 and data_out=7'h35 on cycles 2-5; display_en=0 on cycles 6-7; state IDLE and busy=0 from cycle 8.
2. Burst of 3 bytes 7'h01, 7'h02, 7'h03 on consecutive cycles → each is shown for 4 cycles in order, with display_en high on cycles 2-5, 8-11 and 14-17, and 2-cycle gaps between them.
3. Overflow: 6 bytes 7'h10-7'h15 on consecutive cycles from empty:
   - 7'h10 is popped at cycle 1; 7'h11-7'h14 fill the FIFO; 7'h15 is dropped.
   - overflow=1 from cycle 6, fifo_count=4.
   - clear_overflow at cycle 10 → overflow=0 at cycle 11.
4. Hold: during the second SHOW cycle of 7'h2A, assert hold for 10 cycles → data_out stays 7'h2A and display_en stays 1 for 14 cycles in total.
5. Simultaneous push at full with pop: FIFO full (count=4) with state GAP expiring; rx_valid in the same cycle → byte accepted, overflow stays 0, fifo_count stays 4.
6. Reset mid-SHOW with 2 bytes queued: assert reset asynchronously → immediately display_en=0, data_out=0, fifo_count=0, overflow=0. After release, no stale byte is ever displayed.

Source files
------------

// File: rtl/rx_disp_pkg.sv
// Shared types and defaults for the UART-to-hex-display scheduler.
package rx_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  localparam int unsigned DEF_DWELL_CYCLES = 50_000_000;
  localparam int unsigned DEF_GAP_CYCLES   = 5_000_000;

  // Bits needed for a down-counter that starts at max_val.
  function automatic int unsigned rx_disp_cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rx_disp_fifo.sv
// DEPTH x 7-bit synchronous FIFO; dout shows the head entry, and a push into a full FIFO is accepted when a pop occurs in the same cycle.
module rx_disp_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [6:0]               din,
  output logic [6:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [6:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dout      = r_mem[r_rd];
  assign count     = r_count;

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_display_scheduler.sv
// Buffers received characters and shows each for DWELL_CYCLES, then blanks for GAP_CYCLES.
module rx_display_scheduler
  import rx_disp_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W        = rx_disp_cnt_w(DEF_DWELL_CYCLES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [6:0]             rx_data,
  input  logic                   hold,
  input  logic                   clear_overflow,
  output logic [6:0]             data_out,
  output logic                   display_en,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   overflow
);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [6:0]             r_data;
  logic                   r_en;
  logic                   r_ovf;

  logic [6:0]             w_dout;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_cnt_zero;
  logic                   w_pop;
  logic                   w_drop;

  rx_disp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_valid),
    .pop   (w_pop),
    .din   (rx_data),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_cnt_zero = (r_cnt == '0);
  // Pop exactly on the edges that enter SHOW.
  assign w_pop  = !w_empty &&
                  ((r_state == IDLE) || (r_state == GAP && !hold && w_cnt_zero));
  assign w_drop = rx_valid && w_full && !w_pop;

  assign data_out   = r_data;
  assign display_en = r_en;
  assign fifo_count = w_count;
  assign overflow   = r_ovf;
  assign busy       = (r_state != IDLE) || (w_count != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_data  <= w_dout;
            r_cnt   <= DWELL_LD;
            r_en    <= 1'b1;
            r_state <= SHOW;
          end
        end
        SHOW: begin
          if (!hold) begin
            if (w_cnt_zero) begin
              r_cnt   <= GAP_LD;
              r_en    <= 1'b0;
              r_state <= GAP;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (!hold) begin
            if (w_cnt_zero) begin
              if (w_pop) begin
                r_data  <= w_dout;
                r_cnt   <= DWELL_LD;
                r_en    <= 1'b1;
                r_state <= SHOW;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_display_scheduler.sv
// Directed bench for rx_display_scheduler with DWELL=4, GAP=2, DEPTH=4.
module tb_rx_display_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [6:0] rx_data = '0;
  logic       hold = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [6:0] data_out;
  logic       display_en;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overflow;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  rx_display_scheduler #(
    .DEPTH        (4),
    .DWELL_CYCLES (4),
    .GAP_CYCLES   (2),
    .CNT_W        (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .hold           (hold),
    .clear_overflow (clear_overflow),
    .data_out       (data_out),
    .display_en     (display_en),
    .fifo_count     (fifo_count),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rv;
    logic [6:0] d;
    logic       h;
    logic       c;
    logic       en;
    logic [6:0] dat;
    logic [2:0] cnt;
    logic       bsy;
    logic       ovf;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input int idx, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, sample at the falling edge.
  task automatic step(input logic rv, input logic [6:0] d, input logic h, input logic c);
    @(posedge clock);
    #1;
    rx_valid       = rv;
    rx_data        = d;
    hold           = h;
    clear_overflow = c;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset          = 1'b1;
    rx_valid       = 1'b0;
    rx_data        = '0;
    hold           = 1'b0;
    clear_overflow = 1'b0;
    #1;
    chk("rst_en",   0, display_en, 0);
    chk("rst_data", 0, data_out,   0);
    chk("rst_cnt",  0, fifo_count, 0);
    chk("rst_busy", 0, busy,       0);
    chk("rst_ovf",  0, overflow,   0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned en_ones;

    // single byte 35, then 6-byte overflow burst with clear at c10
    tbl[0]  = '{1'b1, 7'h35, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 3'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h35, 3'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h35, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h35, 3'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h35, 3'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h35, 3'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h35, 3'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h35, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 7'h10, 1'b0, 1'b0, 1'b0, 7'h35, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 7'h11, 1'b0, 1'b0, 1'b0, 7'h35, 3'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 7'h12, 1'b0, 1'b0, 1'b1, 7'h10, 3'd1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 7'h13, 1'b0, 1'b0, 1'b1, 7'h10, 3'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 7'h14, 1'b0, 1'b0, 1'b1, 7'h10, 3'd3, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 7'h15, 1'b0, 1'b0, 1'b1, 7'h10, 3'd4, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h10, 3'd4, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h10, 3'd4, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h11, 3'd3, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h11, 3'd3, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h11, 3'd3, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h11, 3'd3, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h11, 3'd3, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rv, tbl[i].d, tbl[i].h, tbl[i].c);
      chk("tbl_en",   i, display_en, tbl[i].en);
      chk("tbl_data", i, data_out,   tbl[i].dat);
      chk("tbl_cnt",  i, fifo_count, tbl[i].cnt);
      chk("tbl_busy", i, busy,       tbl[i].bsy);
      chk("tbl_ovf",  i, overflow,   tbl[i].ovf);
    end

    // burst 01,02,03: shown on 2-5, 8-11, 14-17, idle from 20
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      logic       exp_en;
      logic [6:0] exp_d;
      step(k <= 2, 7'(k + 1), 1'b0, 1'b0);
      exp_en = (k >= 2 && k <= 5) || (k >= 8 && k <= 11) || (k >= 14 && k <= 17);
      exp_d  = (k < 2) ? 7'h00 : (k < 8) ? 7'h01 : (k < 14) ? 7'h02 : 7'h03;
      chk("burst_en",   k, display_en, exp_en);
      chk("burst_data", k, data_out,   exp_d);
      if (k == 20) chk("burst_busy", k, busy, 0);
    end

    // hold during SHOW cycles 3..12 stretches the display to 14 cycles
    do_reset();
    en_ones = 0;
    for (int k = 0; k <= 17; k++) begin
      step(k == 0, 7'h2A, (k >= 3 && k <= 12), 1'b0);
      if (display_en) en_ones++;
      chk("hold_en",   k, display_en, (k >= 2 && k <= 15));
      chk("hold_data", k, data_out,   (k >= 2) ? 7'h2A : 7'h00);
    end
    chk("hold_total", 0, en_ones, 14);

    // push while full as GAP expires: accepted, no overflow, order kept through wrap
    do_reset();
    for (int k = 0; k <= 35; k++) begin
      logic       rv;
      logic [6:0] d;
      rv = (k <= 4) || (k == 7);
      d  = (k <= 4) ? 7'(8'h40 + k) : 7'h45;
      step(rv, d, 1'b0, 1'b0);
      if (k == 7) chk("full_cnt_pre", k, fifo_count, 4);
      if (k == 8) begin
        chk("full_cnt_post", k, fifo_count, 4);
        chk("full_ovf",      k, overflow,   0);
      end
      if (k >= 2) begin
        chk("full_en", k, display_en, ((k - 2) % 6) < 4);
        chk("full_data", k, data_out, 7'(8'h40 + (k - 2) / 6));
      end
    end

    // async reset mid-SHOW with two bytes queued
    do_reset();
    for (int k = 0; k <= 3; k++) step(k <= 2, 7'(8'h50 + k), 1'b0, 1'b0);
    chk("mid_en",  3, display_en, 1);
    chk("mid_cnt", 3, fifo_count, 2);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_en",   0, display_en, 0);
    chk("arst_data", 0, data_out,   0);
    chk("arst_cnt",  0, fifo_count, 0);
    chk("arst_ovf",  0, overflow,   0);
    chk("arst_busy", 0, busy,       0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 7'h00, 1'b0, 1'b0);
      chk("post_en",   k, display_en, 0);
      chk("post_data", k, data_out,   0);
      chk("post_cnt",  k, fifo_count, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
